// File: rtl/seg_pkg.sv
// seg_pkg: shared scan states, segment patterns and the 16-entry code table
package seg_pkg;
  typedef enum logic [1:0] {S_OFF, S_DEAD, S_DRIVE} state_t;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [5:0] SEL_OFF  = 6'b111111;
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
    7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: combinational 4-bit code to active-low 7-segment pattern
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[code];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: six-digit multiplexed 7-segment scanner with dead time and a write port
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DRIVE_CYC = 50000,
  parameter int DEAD_CYC  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic       wr_ack,
  output logic       wr_err,
  output logic [6:0] seg,
  output logic [5:0] sel,
  output logic       frame_done
);
  localparam int MAXC = DRIVE_CYC > DEAD_CYC ? DRIVE_CYC : DEAD_CYC;
  localparam int CW = $clog2(MAXC);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [4:0] bank [6];
  logic [6:0] dec;
  logic [6:0] shown;
  logic wr_ok;
  seg_decoder u_dec (.code(bank[idx][3:0]), .seg(dec));
  assign shown = bank[idx][4] ? SEG_OFF : dec;
  assign wr_ok = wr_en && wr_addr <= 3'd5;
  // bank writes, handshake pulses and the scan FSM; outputs are registered so
  // they line up with the state they describe and default to all-off
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_OFF;
      cnt <= '0;
      idx <= '0;
      seg <= SEG_OFF;
      sel <= SEL_OFF;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 6; i++) bank[i] <= '0;
    end else begin
      wr_ack <= wr_ok;
      wr_err <= wr_en && !wr_ok;
      if (wr_ok) bank[wr_addr] <= wr_data;
      frame_done <= 1'b0;
      seg <= SEG_OFF;
      sel <= SEL_OFF;
      if (!en) begin
        state <= S_OFF;
        cnt <= '0;
        idx <= '0;
      end else begin
        case (state)
          S_OFF: begin
            state <= S_DEAD;
            cnt <= '0;
            idx <= '0;
          end
          S_DEAD: begin
            if (cnt == CW'(DEAD_CYC - 1)) begin
              state <= S_DRIVE;
              cnt <= '0;
              sel <= SEL_OFF ^ (6'b1 << idx);
              seg <= shown;
            end else cnt <= cnt + 1'b1;
          end
          S_DRIVE: begin
            if (cnt == CW'(DRIVE_CYC - 1)) begin
              state <= S_DEAD;
              cnt <= '0;
              idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
              frame_done <= idx == 3'd5;
            end else begin
              cnt <= cnt + 1'b1;
              sel <= SEL_OFF ^ (6'b1 << idx);
              seg <= shown;
            end
          end
          default: state <= S_OFF;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized and directed check of seg_scan_ctrl against a slot-arithmetic model
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst, en, wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic wr_ack, wr_err, frame_done;
  logic [6:0] seg;
  logic [5:0] sel;
  int n_chk = 0;
  int n_fail = 0;
  int r = -1;
  bit chk = 1'b0;
  logic [4:0] mb [6];
  logic [6:0] e_seg;
  logic [5:0] e_sel;
  logic e_ack, e_err, e_fd;

  seg_scan_ctrl #(.DRIVE_CYC(4), .DEAD_CYC(2)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .seg(seg), .sel(sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [4:0] d);
    if (d[4]) return 7'b1111111;
    case (d[3:0])
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction

  // r counts cycles since the scan started (-1 = off); each 6-cycle slot is 2 dead + 4 drive
  always @(posedge clk) begin
    if (!rst) begin
      r = -1;
      for (int i = 0; i < 6; i++) mb[i] = '0;
      e_ack = 0; e_err = 0; e_fd = 0; e_seg = 7'h7F; e_sel = 6'h3F;
      chk = 1'b1;
    end else begin
      e_ack = wr_en && wr_addr < 6;
      e_err = wr_en && wr_addr > 5;
      r = en ? r + 1 : -1;
      e_fd = r > 0 && r % 36 == 0;
      if (r < 0 || r % 6 < 2) begin
        e_sel = 6'h3F; e_seg = 7'h7F;
      end else begin
        e_sel = 6'h3F ^ (6'b1 << ((r / 6) % 6));
        e_seg = ref_seg(mb[(r / 6) % 6]);
      end
      if (e_ack) mb[wr_addr] = wr_data;
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk) begin
      check("seg", seg, e_seg);
      check("sel", sel, e_sel);
      check("wr_ack", wr_ack, e_ack);
      check("wr_err", wr_err, e_err);
      check("frame_done", frame_done, e_fd);
      check("sel_onehot", $countones(~sel) <= 1, 1);
    end
  end

  task automatic wr(input logic [2:0] a, input logic [4:0] d);
    @(negedge clk);
    wr_en = 1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic wait_sel(input logic [5:0] s, input string nm);
    @(negedge clk);
    for (int i = 0; i < 100 && sel !== s; i++) @(negedge clk);
    check(nm, sel, s);
  endtask

  initial begin
    int fd_cnt, d0_cnt;
    rst = 0; en = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_seg", seg, 7'b1111111);
      check("reset_sel", sel, 6'b111111);
    end
    rst = 1;
    wait_sel(6'b111110, "first_drive_sel");
    check("first_drive_seg", seg, 7'b0000001);
    @(negedge clk);
    en = 0;
    for (int k = 0; k < 6; k++) wr(3'(k), 5'(k + 1));
    @(negedge clk);
    en = 1;
    fd_cnt = 0; d0_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      fd_cnt += int'(frame_done);
      d0_cnt += int'(sel == 6'b111110 && seg == 7'b1001111);
    end
    check("frame_done_count", fd_cnt, 2);
    check("digit0_drive_cycles", d0_cnt, 12);
    @(negedge clk);
    wr_en = 1; wr_addr = 7; wr_data = 5'h1F;
    @(negedge clk);
    wr_en = 0;
    check("err_pulse", wr_err, 1);
    check("err_no_ack", wr_ack, 0);
    @(negedge clk);
    wr_en = 1; wr_addr = 2; wr_data = 5'b10000;
    @(negedge clk);
    wr_en = 0;
    check("ack_pulse", wr_ack, 1);
    wait_sel(6'b111011, "blank_digit_sel");
    check("blank_digit_seg", seg, 7'b1111111);
    wait_sel(6'b111101, "live_sel");
    wr_en = 1; wr_addr = 1; wr_data = 5'd12;
    @(negedge clk);
    wr_en = 0;
    @(negedge clk);
    check("live_seg", seg, 7'b1111110);
    check("live_sel_steady", sel, 6'b111101);
    wait_sel(6'b011111, "digit5_sel");
    @(negedge clk);
    @(negedge clk);
    en = 0;
    @(negedge clk);
    check("drop_sel", sel, 6'b111111);
    check("drop_no_fd", frame_done, 0);
    en = 1;
    @(negedge clk);
    check("restart_dead1", sel, 6'b111111);
    @(negedge clk);
    check("restart_dead2", sel, 6'b111111);
    @(negedge clk);
    check("restart_digit0", sel, 6'b111110);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = $urandom_range(299) != 0;
      if ($urandom_range(49) == 0) en = ~en;
      wr_en = $urandom_range(3) == 0;
      wr_addr = 3'($urandom_range(7));
      wr_data = 5'($urandom);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DRIVE_CYC, default 50000: clock cycles each digit is driven per scan slot (legal range >= 2).
REQ-002 SHALL have parameter DEAD_CYC, default 4: clock cycles of all-off dead time between digit slots (legal range >= 1).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port en, input, 1 bit: scan enable; while low, the display is off.
REQ-006 SHALL have port wr_en, input, 1 bit: write strobe for the digit register bank.
REQ-007 SHALL have port wr_addr, input, 3 bits: digit index 0..5.
REQ-008 SHALL have port wr_data, input, 5 bits: [3:0] code, [4] blank flag for that digit.
REQ-009 SHALL have port wr_ack, output, 1 bit: one-cycle pulse for an accepted write.
REQ-010 SHALL have port wr_err, output, 1 bit: one-cycle pulse for a rejected write (wr_addr > 5).
REQ-011 SHALL have port seg, output, 7 bits: active-low segments, seg[6]=a ... seg[0]=g.
REQ-012 SHALL have port sel, output, 6 bits: active-low one-hot digit select; sel[k]=0 drives digit k.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse when digit 5's drive slot ends.

Function
REQ-014 SHALL hold a bank of six 5-bit digit registers (code + blank flag).
REQ-015 SHALL, for wr_en=1 with wr_addr<=5, update that register at the clock edge and pulse wr_ack on the next cycle; wr_addr 6..7 SHALL leave the bank unchanged and pulse wr_err instead.
REQ-016 SHALL implement states S_OFF, S_DEAD and S_DRIVE, with a cycle counter and a 3-bit digit index idx.
REQ-017 In S_OFF: sel=6'b111111 and seg=7'b1111111; SHALL go to S_DEAD with idx=0 and counter=0 on the first cycle en=1.
REQ-018 In S_DEAD: sel=6'b111111 and seg=7'b1111111 for exactly DEAD_CYC cycles, then S_DRIVE.
REQ-019 In S_DRIVE: sel[idx]=0, all other sel bits 1, for exactly DRIVE_CYC cycles; then idx advances (5 wraps to 0) and the state goes to S_DEAD.
REQ-020 SHALL pulse frame_done for one cycle coincident with the S_DRIVE to S_DEAD transition when idx=5.
REQ-021 SHALL decode in S_DRIVE as follows: 0..9 use 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; codes 10..15 show a dash, 1111110.
REQ-022 SHALL drive seg=7'b1111111 for a digit whose blank flag is set, with sel still asserted for that digit.
REQ-023 SHALL register seg and sel; a write to the currently driven digit SHALL appear on seg no later than 2 cycles after wr_en.
REQ-024 en falling in any state SHALL force S_OFF on the next cycle; no partial slot completes and frame_done does not pulse.
REQ-025 SHALL accept writes in every state, including S_OFF; a simultaneous write and en change SHALL both take effect.
REQ-026 sel SHALL never have more than one bit low in any cycle.

Reset
REQ-027 When rst=0 at a clock edge: state=S_OFF, idx=0, counter=0, all digit registers=5'b00000, seg=7'b1111111, sel=6'b111111, wr_ack=0, wr_err=0, frame_done=0.
REQ-028 Reset SHALL override en and wr_en in the same cycle, and reset mid-slot SHALL blank the outputs on the next cycle.

Structure
REQ-029 Package seg_pkg SHALL hold the state enum, the 16-entry segment table, SEG_OFF=7'b1111111, SEG_DASH=7'b1111110 and SEL_OFF=6'b111111.
REQ-030 The code-to-segment lookup SHALL be a combinational sub-module seg_decoder (4-bit code in, 7-bit seg out), instantiated once.
REQ-031 The counter width SHALL be derived from max(DRIVE_CYC, DEAD_CYC) via $clog2.

Verification (DRIVE_CYC=4, DEAD_CYC=2)
REQ-032 Reset scenario: hold rst=0 for 3 cycles with en=1 -> seg=1111111 and sel=111111 throughout; after release, the first S_DRIVE shows digit 0 with sel=111110 and seg=0000001.
REQ-033 Full frame scenario: write digits 0..5 = 1,2,3,4,5,6, then en=1 -> sel walks 111110..011111, each low for 4 cycles, separated by 2 all-off cycles; seg is correct per digit; frame_done pulses once per 36 cycles.
REQ-034 Write handshake scenario: wr_addr=7 -> wr_err pulse, bank unchanged; wr_addr=2, data=5'b10000 -> wr_ack pulse, digit 2 driven with seg=1111111.
REQ-035 Live update scenario: write code 12 to the digit currently in S_DRIVE -> seg=1111110 within 2 cycles, with no sel glitch.
REQ-036 Enable drop scenario: drop en in the 3rd drive cycle of digit 5 -> all-off the next cycle, no frame_done; on re-enable, the scan restarts at digit 0 after 2 dead cycles.
REQ-037 Assertion: REQ-026 one-hot-or-zero on sel is checked every cycle of every scenario.
